// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with hardwired zero register, optional write-to-read
// bypass and a per-register busy scoreboard between decode/issue and writeback.

module regfile_scoreboard_rdport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  i_regs,
  input  logic [DEPTH-1:0]             i_busy,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_reg,
  input  logic [WIDTH-1:0]             i_wr_data,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_busy
);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  always_comb begin
    o_data = i_regs[i_addr];
    o_busy = i_busy[i_addr];
    if (BYPASS && i_wr_en && (i_wr_reg == i_addr)) begin
      o_data = i_wr_data;
      o_busy = 1'b0;
    end
    // Zero register overrides everything, including a forwarded write.
    if (i_addr == ZR) begin
      o_data = '0;
      o_busy = 1'b0;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  output logic [NUM_RD*WIDTH-1:0]  readData,
  output logic [NUM_RD-1:0]        readBusy,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [WIDTH-1:0]         writeData,
  input  logic                     regWrEn,
  input  logic                     busySet,
  input  logic [ADDR_W-1:0]        busyReg
);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0][WIDTH-1:0] r_regs;
  logic [DEPTH-1:0]            r_busy;
  logic [DEPTH-1:0]            w_busy_nxt;

  // Set is applied after clear so a new producer issued on the writeback edge wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (regWrEn) w_busy_nxt[writeReg] = 1'b0;
    if (busySet) w_busy_nxt[busyReg]  = 1'b1;
    w_busy_nxt[ZR] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      if (regWrEn && (writeReg != ZR)) r_regs[writeReg] <= writeData;
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_scoreboard_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .i_addr   (readReg[p*ADDR_W +: ADDR_W]),
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_wr_en  (regWrEn),
      .i_wr_reg (writeReg),
      .i_wr_data(writeData),
      .o_data   (readData[p*WIDTH +: WIDTH]),
      .o_busy   (readBusy[p])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default configuration (BYPASS=1) and a narrow
// 32x16, 3-port, ZERO_REG=0, BYPASS=0 configuration driven through shared tasks.

module tb_regfile_scoreboard;
  localparam logic [63:0] K = 64'h0000010204080001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // generic per-DUT stimulus/response views (index 0 = default, 1 = narrow)
  logic        wen  [2];
  logic [4:0]  wreg [2];
  logic [63:0] wdat [2];
  logic        bset [2];
  logic [4:0]  breg [2];
  logic [4:0]  raddr[2][4];
  logic [63:0] rdata[2][4];
  logic        rbusy[2][4];

  int unsigned DEPTHS[2] = '{32, 16};
  int unsigned NRD   [2] = '{2, 3};
  int unsigned ZREG  [2] = '{31, 0};
  bit          BYP   [2] = '{1'b1, 1'b0};

  logic [127:0] d0_rd;  logic [1:0] d0_rb;
  logic [95:0]  d1_rd;  logic [2:0] d1_rb;
  logic [9:0]   d0_rr;
  logic [11:0]  d1_rr;

  assign d0_rr = {raddr[0][1], raddr[0][0]};
  assign d1_rr = {raddr[1][2][3:0], raddr[1][1][3:0], raddr[1][0][3:0]};

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[0][p] = '0; rbusy[0][p] = 1'b0;
      rdata[1][p] = '0; rbusy[1][p] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      rdata[0][p] = d0_rd[p*64 +: 64];
      rbusy[0][p] = d0_rb[p];
    end
    for (int p = 0; p < 3; p++) begin
      rdata[1][p] = {32'h0, d1_rd[p*32 +: 32]};
      rbusy[1][p] = d1_rb[p];
    end
  end

  regfile_scoreboard #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .readReg(d0_rr), .readData(d0_rd), .readBusy(d0_rb),
    .writeReg(wreg[0]), .writeData(wdat[0]), .regWrEn(wen[0]),
    .busySet(bset[0]), .busyReg(breg[0])
  );

  regfile_scoreboard #(.WIDTH(32), .DEPTH(16), .NUM_RD(3), .ZERO_REG(0), .BYPASS(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .readReg(d1_rr), .readData(d1_rd), .readBusy(d1_rb),
    .writeReg(wreg[1][3:0]), .writeData(wdat[1][31:0]), .regWrEn(wen[1]),
    .busySet(bset[1]), .busyReg(breg[1][3:0])
  );

  typedef struct {
    string       name;
    int          port;
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [63:0] msk(int d, logic [63:0] v);
    return (d == 0) ? v : (v & 64'h0000_0000_FFFF_FFFF);
  endfunction

  task automatic push(string name, int d, int port, logic [63:0] data, logic busy);
    q.push_back('{name, port, msk(d, data), busy});
  endtask

  task automatic idle(int d);
    wen[d] = 1'b0; wreg[d] = '0; wdat[d] = '0; bset[d] = 1'b0; breg[d] = '0;
  endtask

  task automatic test_reset(int d);
    @(negedge clk);
    reset_n = 1'b0;
    idle(d);
    for (int p = 0; p < 4; p++) raddr[d][p] = 5'd3;
    #1;
    for (int p = 0; p < int'(NRD[d]); p++) push("rst_init", d, p, 64'h0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    wen[d] = 1'b1; wreg[d] = 5'd3; wdat[d] = 64'hA5; bset[d] = 1'b1; breg[d] = 5'd9;
    @(negedge clk);
    idle(d);
    raddr[d][0] = 5'd3; raddr[d][1] = 5'd9; raddr[d][2] = 5'd3;
    #1;
    push("rst_pre_x3", d, 0, 64'hA5, 1'b0);
    push("rst_pre_x9", d, 1, 64'h0, 1'b1);
    if (NRD[d] > 2) push("rst_pre_x3b", d, 2, 64'hA5, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
    #1 reset_n = 1'b0;   // mid-cycle, well before the next rising edge
    #1;
    for (int p = 0; p < int'(NRD[d]); p++) push("rst_async", d, p, 64'h0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    wen[d] = 1'b1; wreg[d] = 5'd3; wdat[d] = 64'h5A;
    @(negedge clk);
    idle(d);
    #1;
    push("rst_after_wr", d, 0, 64'h5A, 1'b0);
    push("rst_after_x9", d, 1, 64'h0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_zero(int d);
    @(negedge clk);
    wen[d] = 1'b1; wreg[d] = 5'(ZREG[d]); wdat[d] = 64'hA0;
    bset[d] = 1'b1; breg[d] = 5'(ZREG[d]);
    for (int p = 0; p < 4; p++) raddr[d][p] = 5'(ZREG[d]);
    #1;
    for (int p = 0; p < int'(NRD[d]); p++) push("zero_same", d, p, 64'h0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
    @(negedge clk);
    idle(d);
    #1;
    for (int p = 0; p < int'(NRD[d]); p++) push("zero_after", d, p, 64'h0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_pattern(int d);
    int a;
    for (int i = 0; i < int'(DEPTHS[d]); i++) begin
      @(negedge clk);
      wen[d] = 1'b1; wreg[d] = 5'(i); wdat[d] = 64'(i) * K;
    end
    @(negedge clk);
    idle(d);
    for (int i = 0; i < int'(DEPTHS[d]); i++) begin
      for (int p = 0; p < int'(NRD[d]); p++) begin
        a = (i - p + int'(DEPTHS[d])) % int'(DEPTHS[d]);
        raddr[d][p] = 5'(a);
        push("pattern", d, p, (a == int'(ZREG[d])) ? 64'h0 : 64'(a) * K, 1'b0);
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
          errors++;
          $display("FAIL %s d%0d p%0d i%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, d, e.port, i, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bypass(int d);
    @(negedge clk);
    wen[d] = 1'b1; wreg[d] = 5'd5; wdat[d] = 64'h11;
    @(negedge clk);
    wdat[d] = 64'h22;
    raddr[d][0] = 5'd5;
    #1;
    push("bypass_same", d, 0, BYP[d] ? 64'h22 : 64'h11, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
    @(negedge clk);
    idle(d);
    #1;
    push("bypass_next", d, 0, 64'h22, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
  endtask

  // X7/X8 still hold their pattern values when this runs
  task automatic test_scoreboard(int d);
    logic [63:0] k7, k8;
    k7 = 64'd7 * K;
    k8 = 64'd8 * K;
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      idle(d);
      raddr[d][0] = 5'd7; raddr[d][1] = 5'd8;
      case (s)
        0: begin bset[d] = 1'b1; breg[d] = 5'd7; end
        2: begin wen[d] = 1'b1; wreg[d] = 5'd7; wdat[d] = 64'h77; end
        4: begin bset[d] = 1'b1; breg[d] = 5'd7; wen[d] = 1'b1; wreg[d] = 5'd7; wdat[d] = 64'h78; end
        6: begin wen[d] = 1'b1; wreg[d] = 5'd7; wdat[d] = 64'h79; bset[d] = 1'b1; breg[d] = 5'd8; end
        8: begin bset[d] = 1'b1; breg[d] = 5'd8; end
        default: ;
      endcase
      #1;
      case (s)
        0: push("sb_set_same", d, 0, k7, 1'b0);
        1: push("sb_set_next", d, 0, k7, 1'b1);
        2: push("sb_wb_same", d, 0, BYP[d] ? 64'h77 : k7, BYP[d] ? 1'b0 : 1'b1);
        3: push("sb_wb_next", d, 0, 64'h77, 1'b0);
        4: push("sb_setclr_same", d, 0, BYP[d] ? 64'h78 : 64'h77, 1'b0);
        5: push("sb_setclr_next", d, 0, 64'h78, 1'b1);
        6: begin
             push("sb_diff_x7_same", d, 0, BYP[d] ? 64'h79 : 64'h78, BYP[d] ? 1'b0 : 1'b1);
             push("sb_diff_x8_same", d, 1, k8, 1'b0);
           end
        7: begin
             push("sb_diff_x7_next", d, 0, 64'h79, 1'b0);
             push("sb_diff_x8_next", d, 1, k8, 1'b1);
           end
        default: push("sb_reset_busy", d, 1, k8, 1'b1);
      endcase
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
          errors++;
          $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
        end
      end
    end
    @(negedge clk);
    idle(d);
    #1;
    push("sb_rebusy_hold", d, 1, k8, 1'b1);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (rdata[d][e.port] !== e.data || rbusy[d][e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s d%0d p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, d, e.port, rdata[d][e.port], rbusy[d][e.port], e.data, e.busy);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle(d);
      for (int p = 0; p < 4; p++) raddr[d][p] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      test_reset(d);
      test_zero(d);
      test_pattern(d);
      test_bypass(d);
      test_scoreboard(d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
